// File: rtl/lsu_ctrl.sv
// Load/store unit between the execute stage and the data memory: decodes width,
// checks alignment, drives one memory access and returns extended load data.
module lsu_ctrl #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_isStore,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  output logic        mem_enable,
  output logic        mem_rw,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

  // SETUP is a one-cycle address phase ahead of the enabled access window.
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} stateT;

  stateT       state;
  stateT       nextState;
  logic [31:0] addrQ;
  logic [31:0] wdataQ;
  logic [2:0]  funct3Q;
  logic        isStoreQ;
  logic [CW-1:0] cnt;
  logic [31:0] rdataQ;
  logic        errQ;

  logic        accept;
  logic        reqIllegal;
  logic        reqMisaligned;
  logic        reqErr;
  logic [31:0] shifted;
  logic [31:0] loadData;
  logic [3:0]  byteMask;

  assign accept = in_valid && in_ready;
  assign reqErr = reqIllegal || reqMisaligned;

  always_comb begin
    reqIllegal    = 1'b0;
    reqMisaligned = 1'b0;
    if (in_isStore)
      reqIllegal = in_funct3[2] || (in_funct3 == 3'b011);
    else
      reqIllegal = (in_funct3 == 3'b011) || (in_funct3[2:1] == 2'b11);
    case (in_funct3[1:0])
      2'b01:   reqMisaligned = in_addr[0];
      2'b10:   reqMisaligned = |in_addr[1:0];
      default: reqMisaligned = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = reqErr ? RESP : SETUP;
      SETUP:   nextState = ACCESS;
      ACCESS:  if (cnt == '0) nextState = RESP;
      RESP:    if (out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Request fields are latched once and held for the whole access and response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addrQ    <= '0;
      wdataQ   <= '0;
      funct3Q  <= '0;
      isStoreQ <= 1'b0;
      cnt      <= '0;
      rdataQ   <= '0;
      errQ     <= 1'b0;
    end else begin
      if (accept) begin
        addrQ    <= in_addr;
        wdataQ   <= in_wdata;
        funct3Q  <= in_funct3;
        isStoreQ <= in_isStore;
        cnt      <= CNT_INIT;
        rdataQ   <= '0;
        errQ     <= reqErr;
      end
      if (state == ACCESS) begin
        if (cnt != '0)
          cnt <= cnt - 1'b1;
        else if (!isStoreQ)
          rdataQ <= loadData;
      end
    end
  end

  assign shifted = mem_rdata >> {addrQ[1:0], 3'b000};

  always_comb begin
    loadData = shifted;
    case (funct3Q)
      3'b000:  loadData = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  loadData = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  loadData = {24'h000000, shifted[7:0]};
      3'b101:  loadData = {16'h0000, shifted[15:0]};
      default: loadData = shifted;
    endcase
  end

  always_comb begin
    byteMask = 4'b1111;
    case (funct3Q[1:0])
      2'b00:   byteMask = 4'b0001 << addrQ[1:0];
      2'b01:   byteMask = 4'b0011 << addrQ[1:0];
      default: byteMask = 4'b1111;
    endcase
  end

  always_comb begin
    in_ready   = (state == IDLE);
    out_valid  = (state == RESP);
    mem_enable = (state == ACCESS);
    mem_rw     = (state == ACCESS) && isStoreQ;
    mem_wmask  = (state == ACCESS) ? {4'b0000, byteMask} : 8'h00;
    mem_addr   = {addrQ[31:2], 2'b00};
    mem_wdata  = wdataQ << {addrQ[1:0], 3'b000};
    out_rdata  = rdataQ;
    out_err    = errQ;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: runs a latency-1 and a latency-3 instance side by side against
// a transaction-level model, plus hand-computed expectations for the key accesses.
module tb_lsu_ctrl;

  logic        clock;
  logic        reset;
  logic        inValid;
  logic        inIsStore;
  logic [2:0]  inFunct3;
  logic [31:0] inAddr;
  logic [31:0] inWdata;
  logic        outReady;

  logic        inReady   [2];
  logic        outValid  [2];
  logic [31:0] outRdata  [2];
  logic        outErr    [2];
  logic [31:0] memAddr   [2];
  logic [31:0] memWdata  [2];
  logic [7:0]  memWmask  [2];
  logic        memEnable [2];
  logic        memRw     [2];
  logic [31:0] memRdata  [2];

  logic [31:0] memArr [16];

  int checks = 0;
  int errors = 0;

  lsu_ctrl #(.MEM_LATENCY(1)) uLat1 (
    .clock(clock), .reset(reset),
    .in_valid(inValid), .in_ready(inReady[0]), .in_isStore(inIsStore),
    .in_funct3(inFunct3), .in_addr(inAddr), .in_wdata(inWdata),
    .out_valid(outValid[0]), .out_ready(outReady), .out_rdata(outRdata[0]), .out_err(outErr[0]),
    .mem_addr(memAddr[0]), .mem_wdata(memWdata[0]), .mem_wmask(memWmask[0]),
    .mem_enable(memEnable[0]), .mem_rw(memRw[0]), .mem_rdata(memRdata[0])
  );

  lsu_ctrl #(.MEM_LATENCY(3)) uLat3 (
    .clock(clock), .reset(reset),
    .in_valid(inValid), .in_ready(inReady[1]), .in_isStore(inIsStore),
    .in_funct3(inFunct3), .in_addr(inAddr), .in_wdata(inWdata),
    .out_valid(outValid[1]), .out_ready(outReady), .out_rdata(outRdata[1]), .out_err(outErr[1]),
    .mem_addr(memAddr[1]), .mem_wdata(memWdata[1]), .mem_wmask(memWmask[1]),
    .mem_enable(memEnable[1]), .mem_rw(memRw[1]), .mem_rdata(memRdata[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign memRdata[0] = memArr[memAddr[0][5:2]];
  assign memRdata[1] = memArr[memAddr[1][5:2]];

  // Memory shared by both instances; reset reloads the preset contents.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) memArr[i] <= 32'h0;
      memArr[4] <= 32'hDEADBEEF;
    end else begin
      for (int d = 0; d < 2; d++)
        if (memEnable[d] && memRw[d])
          for (int b = 0; b < 4; b++)
            if (memWmask[d][b]) memArr[memAddr[d][5:2]][8*b +: 8] <= memWdata[d][8*b +: 8];
    end
  end

  function automatic int latOf(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic [7:0]  mask;
    logic [31:0] wdata;
  } expT;

  function automatic expT predict(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] word);
    expT e;
    int size;
    int o;
    logic legal;
    logic [31:0] lowMask;
    logic [31:0] v;
    e.err = 1'b0; e.rdata = 32'h0; e.mask = 8'h0; e.wdata = 32'h0;
    o = int'(a[1:0]);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal || (a % size) != 0) begin
      e.err = 1'b1;
      return e;
    end
    e.mask  = 8'(((1 << size) - 1) << o);
    e.wdata = wd << (8 * o);
    if (!st) begin
      lowMask = (size == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * size)) - 32'd1);
      v = (word >> (8 * o)) & lowMask;
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~lowMask;
      e.rdata = v;
    end
    return e;
  endfunction

  // Model: cycle k=1 follows the accepting edge; the response window opens at mStart.
  bit          mBusy  [2];
  int          mK     [2];
  int          mStart [2];
  logic        mErr   [2];
  logic        mStore [2];
  logic [31:0] mRdata [2];
  logic [31:0] mWdata [2];
  logic [7:0]  mMask  [2];
  logic [31:0] mAddr  [2];

  always @(posedge clock or posedge reset) begin : modelProc
    expT e;
    if (reset) begin
      for (int d = 0; d < 2; d++) mBusy[d] <= 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (!mBusy[d]) begin
          if (inValid) begin
            e = predict(inIsStore, inFunct3, inAddr, inWdata, memArr[inAddr[5:2]]);
            mBusy[d]  <= 1'b1;
            mK[d]     <= 1;
            mStart[d] <= e.err ? 1 : latOf(d) + 2;
            mErr[d]   <= e.err;
            mStore[d] <= inIsStore;
            mRdata[d] <= e.rdata;
            mWdata[d] <= e.wdata;
            mMask[d]  <= e.mask;
            mAddr[d]  <= {inAddr[31:2], 2'b00};
          end
        end else if (mK[d] >= mStart[d] && outReady) begin
          mBusy[d] <= 1'b0;
        end else begin
          mK[d] <= mK[d] + 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin : compareProc
    logic expEn;
    logic expValid;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        checkOutput($sformatf("rst_out_valid[%0d]", d), 32'(outValid[d]), 32'h0);
        checkOutput($sformatf("rst_mem_enable[%0d]", d), 32'(memEnable[d]), 32'h0);
        checkOutput($sformatf("rst_out_rdata[%0d]", d), outRdata[d], 32'h0);
        checkOutput($sformatf("rst_out_err[%0d]", d), 32'(outErr[d]), 32'h0);
      end else begin
        expEn    = mBusy[d] && !mErr[d] && (mK[d] >= mStart[d] - latOf(d)) && (mK[d] < mStart[d]);
        expValid = mBusy[d] && (mK[d] >= mStart[d]);
        checkOutput($sformatf("in_ready[%0d]", d), 32'(inReady[d]), 32'(!mBusy[d]));
        checkOutput($sformatf("mem_enable[%0d]", d), 32'(memEnable[d]), 32'(expEn));
        checkOutput($sformatf("out_valid[%0d]", d), 32'(outValid[d]), 32'(expValid));
        if (expEn) begin
          checkOutput($sformatf("mem_addr[%0d]", d), memAddr[d], mAddr[d]);
          checkOutput($sformatf("mem_wmask[%0d]", d), 32'(memWmask[d]), 32'(mMask[d]));
          checkOutput($sformatf("mem_rw[%0d]", d), 32'(memRw[d]), 32'(mStore[d]));
          if (mStore[d]) checkOutput($sformatf("mem_wdata[%0d]", d), memWdata[d], mWdata[d]);
        end else begin
          checkOutput($sformatf("mem_wmask_idle[%0d]", d), 32'(memWmask[d]), 32'h0);
        end
        if (expValid) begin
          checkOutput($sformatf("out_rdata[%0d]", d), outRdata[d], mRdata[d]);
          checkOutput($sformatf("out_err[%0d]", d), 32'(outErr[d]), 32'(mErr[d]));
        end
      end
    end
  end

  logic [31:0] capRdata [2];
  logic        capErr   [2];
  int          capLat   [2];
  int          capEn    [2];
  logic [7:0]  capMask  [2];
  logic [31:0] capWdata [2];
  logic        capRw    [2];
  logic [31:0] capAddr  [2];

  // Issues one request (called just after a falling edge) and waits for both responses.
  task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input int hold);
    bit got [2];
    bit done;
    int lastValid;
    for (int d = 0; d < 2; d++) begin
      got[d] = 1'b0; capRdata[d] = 32'h0; capErr[d] = 1'b0; capLat[d] = 0; capEn[d] = 0;
      capMask[d] = 8'h0; capWdata[d] = 32'h0; capRw[d] = 1'b0; capAddr[d] = 32'h0;
    end
    inValid = 1'b1; inIsStore = st; inFunct3 = f3; inAddr = a; inWdata = wd;
    outReady = (hold == 0);
    lastValid = 0;
    done = 1'b0;
    @(posedge clock);
    for (int cnt = 1; cnt <= 60 && !done; cnt++) begin
      @(negedge clock);
      if (cnt == 1) inValid = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if (memEnable[d]) begin
          capEn[d]++;
          capMask[d] = memWmask[d]; capWdata[d] = memWdata[d];
          capRw[d] = memRw[d]; capAddr[d] = memAddr[d];
        end
        if (outValid[d] && !got[d]) begin
          got[d] = 1'b1; capLat[d] = cnt; capRdata[d] = outRdata[d]; capErr[d] = outErr[d];
          lastValid = cnt;
        end
      end
      if (got[0] && got[1] && !outReady && cnt >= lastValid + hold) outReady = 1'b1;
      if (got[0] && got[1] && outReady && inReady[0] && inReady[1]) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: response not completed for addr 0x%08h, got %0d/%0d, required 1/1",
               a, got[0], got[1]);
      outReady = 1'b1;
    end
  endtask

  initial begin
    $display("[TB] lsu_ctrl bench start");
    reset = 1'b1; inValid = 1'b0; inIsStore = 1'b0; inFunct3 = 3'b0;
    inAddr = 32'h0; inWdata = 32'h0; outReady = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("reset_in_ready", 32'(inReady[0]), 32'h1);
    checkOutput("reset_out_valid", 32'(outValid[1]), 32'h0);

    applyStimulus(1'b0, 3'b010, 32'h80000010, 32'h0, 0);
    checkOutput("lw_rdata_l1", capRdata[0], 32'hDEADBEEF);
    checkOutput("lw_rdata_l3", capRdata[1], 32'hDEADBEEF);
    checkOutput("lw_latency_l1", 32'(capLat[0]), 32'd3);
    checkOutput("lw_latency_l3", 32'(capLat[1]), 32'd5);
    checkOutput("lw_enable_l1", 32'(capEn[0]), 32'd1);
    checkOutput("lw_enable_l3", 32'(capEn[1]), 32'd3);
    checkOutput("lw_addr", capAddr[0], 32'h80000010);

    applyStimulus(1'b1, 3'b010, 32'h80000010, 32'h80FF1234, 0);
    checkOutput("sw_mask", 32'(capMask[0]), 32'h0F);
    checkOutput("sw_rw", 32'(capRw[0]), 32'h1);
    checkOutput("sw_rdata", capRdata[0], 32'h0);

    applyStimulus(1'b0, 3'b000, 32'h80000013, 32'h0, 0);
    checkOutput("lb_rdata", capRdata[0], 32'hFFFFFF80);
    applyStimulus(1'b0, 3'b100, 32'h80000013, 32'h0, 0);
    checkOutput("lbu_rdata", capRdata[1], 32'h00000080);
    applyStimulus(1'b0, 3'b001, 32'h80000012, 32'h0, 0);
    checkOutput("lh_rdata", capRdata[0], 32'hFFFF80FF);

    applyStimulus(1'b1, 3'b001, 32'h80000002, 32'h0000ABCD, 0);
    checkOutput("sh_mask", 32'(capMask[0]), 32'h0C);
    checkOutput("sh_wdata", capWdata[0], 32'hABCD0000);
    checkOutput("sh_rw", 32'(capRw[1]), 32'h1);
    checkOutput("sh_rdata", capRdata[0], 32'h0);
    checkOutput("sh_err", 32'(capErr[0]), 32'h0);
    applyStimulus(1'b0, 3'b010, 32'h80000000, 32'h0, 0);
    checkOutput("lw_after_sh", capRdata[0], 32'hABCD0000);
    applyStimulus(1'b0, 3'b101, 32'h80000002, 32'h0, 0);
    checkOutput("lhu_rdata", capRdata[1], 32'h0000ABCD);

    applyStimulus(1'b0, 3'b010, 32'h80000001, 32'h0, 0);
    checkOutput("lw_mis_err", 32'(capErr[0]), 32'h1);
    checkOutput("lw_mis_latency_l1", 32'(capLat[0]), 32'd1);
    checkOutput("lw_mis_latency_l3", 32'(capLat[1]), 32'd1);
    checkOutput("lw_mis_enable", 32'(capEn[0] + capEn[1]), 32'd0);
    checkOutput("lw_mis_rdata", capRdata[0], 32'h0);
    applyStimulus(1'b0, 3'b011, 32'h80000010, 32'h0, 0);
    checkOutput("f3_011_err", 32'(capErr[1]), 32'h1);
    checkOutput("f3_011_enable", 32'(capEn[1]), 32'd0);
    applyStimulus(1'b1, 3'b100, 32'h80000010, 32'h0, 0);
    checkOutput("st_f3_100_err", 32'(capErr[0]), 32'h1);
    applyStimulus(1'b0, 3'b001, 32'h80000011, 32'h0, 0);
    checkOutput("lh_mis_err", 32'(capErr[0]), 32'h1);

    applyStimulus(1'b1, 3'b000, 32'h80000007, 32'h12345678, 0);
    checkOutput("sb_mask", 32'(capMask[0]), 32'h08);
    checkOutput("sb_wdata", capWdata[1], 32'h78000000);

    applyStimulus(1'b0, 3'b010, 32'h80000010, 32'h0, 5);
    checkOutput("bp_enable_l3", 32'(capEn[1]), 32'd3);
    checkOutput("bp_rdata_l3", capRdata[1], 32'h80FF1234);

    // Abort an access in flight: latency-3 instance is mid-ACCESS when reset hits.
    inValid = 1'b1; inIsStore = 1'b0; inFunct3 = 3'b010; inAddr = 32'h80000010;
    outReady = 1'b1;
    @(posedge clock);
    @(negedge clock);
    inValid = 1'b0;
    @(negedge clock);
    checkOutput("pre_abort_enable", 32'(memEnable[1]), 32'h1);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_enable", 32'(memEnable[1]), 32'h0);
    checkOutput("abort_valid", 32'(outValid[0]), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    checkOutput("post_abort_ready", 32'(inReady[1]), 32'h1);
    checkOutput("post_abort_valid", 32'(outValid[1]), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
